// File: rtl/io_map_pkg.sv
// Shared address map and debounce state encoding for the LED/switch I/O peripheral.
package io_map_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

  localparam logic [31:0] LED_LO = 32'h0000_0060;
  localparam logic [31:0] LED_HI = 32'h0000_0062;
  localparam logic [31:0] SW_LO  = 32'h0000_0070;
  localparam logic [31:0] SW_HI  = 32'h0000_0072;
  localparam logic [31:0] SW_CHG = 32'h0000_0074;

  typedef enum logic {
    STABLE,
    COUNTING
  } db_state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer followed by a stability-counting debounce FSM.
module switch_debouncer
  import io_map_pkg::*;
#(
  parameter int DATA_W          = 24,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] switch_in,
  output logic [DATA_W-1:0] sw_db,
  output logic              commit
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] sync_p0;
  logic [DATA_W-1:0] sync_p1;
  logic [DATA_W-1:0] cand;
  logic [CNT_W-1:0]  count;
  db_state_t         state;

  // stage p0/p1: metastability synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= switch_in;
      sync_p1 <= sync_p0;
    end
  end

  // Decoded from registered state so the top can set its change flag on the
  // same edge that sw_db takes the new value.
  assign commit = (state == COUNTING) && (sync_p1 == cand) && (count >= CNT_LAST);

  // stage p2: debounce FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      count <= '0;
      cand  <= '0;
      sw_db <= '0;
    end else begin
      case (state)
        STABLE: begin
          if (sync_p1 != sw_db) begin
            state <= COUNTING;
            count <= CNT_ONE;
            cand  <= sync_p1;
          end else begin
            count <= '0;
          end
        end
        COUNTING: begin
          if (sync_p1 != cand) begin
            state <= STABLE;
            count <= '0;
          end else if (commit) begin
            sw_db <= cand;
            state <= STABLE;
            count <= '0;
          end else begin
            count <= count + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_switch_io.sv
// Memory-mapped LED/switch peripheral: address decode, LED registers,
// sticky switch-change flag and zero-latency read mux.
module led_switch_io
  import io_map_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 200000,
  parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        led_ctrl,
  input  logic        switch_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [23:0] switch_in,
  output logic [23:0] led_out,
  output logic [15:0] io_rdata
);

  logic        hit_led_lo;
  logic        hit_led_hi;
  logic        hit_sw_lo;
  logic        hit_sw_hi;
  logic        hit_sw_chg;
  logic [23:0] sw_db;
  logic        commit;
  logic        chg;
  logic        wdata_unused;

  assign hit_led_lo = (addr == IO_BASE + LED_LO);
  assign hit_led_hi = (addr == IO_BASE + LED_HI);
  assign hit_sw_lo  = (addr == IO_BASE + SW_LO);
  assign hit_sw_hi  = (addr == IO_BASE + SW_HI);
  assign hit_sw_chg = (addr == IO_BASE + SW_CHG);

  assign wdata_unused = ^wdata[31:16];

  switch_debouncer #(
    .DATA_W          (24),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .rst_n     (rst_n),
    .switch_in (switch_in),
    .sw_db     (sw_db),
    .commit    (commit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
    end else begin
      if (led_ctrl && hit_led_lo) led_out[15:0]  <= wdata[15:0];
      if (led_ctrl && hit_led_hi) led_out[23:16] <= wdata[7:0];
    end
  end

  // A commit landing on the clearing read's edge must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg <= 1'b0;
    end else if (commit) begin
      chg <= 1'b1;
    end else if (switch_ctrl && hit_sw_chg) begin
      chg <= 1'b0;
    end
  end

  always_comb begin
    io_rdata = '0;
    if (switch_ctrl) begin
      if (hit_led_lo)      io_rdata = led_out[15:0];
      else if (hit_led_hi) io_rdata = {8'h00, led_out[23:16]};
      else if (hit_sw_lo)  io_rdata = sw_db[15:0];
      else if (hit_sw_hi)  io_rdata = {8'h00, sw_db[23:16]};
      else if (hit_sw_chg) io_rdata = {15'h0000, chg};
    end
  end

endmodule
